// File: rtl/not1.sv
// Triple-redundant inverter: gate-level, dataflow and behavioural paths cross-checked
// every tick, with a registered result and saturating vector/error counters.

module not1_gate #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   output wire  [WIDTH-1:0] y
);
   // One NOT primitive per bit
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      not u_not (y[i], a[i]);
   end
endmodule

module not1_dataflow #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   assign y = ~a;
endmodule

module not1_behavioral #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   // Bitwise inversion keeps X/Z inputs as X rather than resolving them
   always_comb begin
      y = ~a;
   end
endmodule

module not1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 32
) (
   input  logic             tick,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   output wire  [WIDTH-1:0] y_gate,
   output logic [WIDTH-1:0] y_data,
   output logic [WIDTH-1:0] y_beh,
   output logic [WIDTH-1:0] y_reg,
   output logic             mismatch,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             mismatch_s;
   logic [WIDTH-1:0] y_reg_r;
   logic             mismatch_r;
   logic [CNT_W-1:0] vec_count_r;
   logic [CNT_W-1:0] err_count_r;

   not1_gate       #(.WIDTH(WIDTH)) u_gate (.a(a), .y(y_gate));
   not1_dataflow   #(.WIDTH(WIDTH)) u_data (.a(a), .y(y_data));
   not1_behavioral #(.WIDTH(WIDTH)) u_beh  (.a(a), .y(y_beh));

   // Case-inequality so an X on one path against a known value on another is flagged
   assign mismatch_s = (y_gate !== y_data) || (y_data !== y_beh) || (y_gate !== y_beh);

   // Registered result, disagreement flag and saturating counters
   always_ff @(posedge tick or posedge reset) begin
      if (reset) begin
         y_reg_r     <= {WIDTH{1'b0}};
         mismatch_r  <= 1'b0;
         vec_count_r <= {CNT_W{1'b0}};
         err_count_r <= {CNT_W{1'b0}};
      end else begin
         y_reg_r    <= ~a;
         mismatch_r <= mismatch_s;
         if (vec_count_r != CNT_MAX) begin
            vec_count_r <= vec_count_r + CNT_ONE;
         end else begin
            vec_count_r <= vec_count_r;
         end
         if (mismatch_s && (err_count_r != CNT_MAX)) begin
            err_count_r <= err_count_r + CNT_ONE;
         end else begin
            err_count_r <= err_count_r;
         end
      end
   end

   assign y_reg     = y_reg_r;
   assign mismatch  = mismatch_r;
   assign vec_count = vec_count_r;
   assign err_count = err_count_r;
endmodule

// File: tb/tb_not1.sv
// Randomised self-checking bench for not1: an 8-bit/32-bit-counter instance and a
// 1-bit/3-bit-counter instance share clock and reset; a counting model predicts outputs.

module tb_not1;
   localparam int W  = 8;
   localparam int CW = 32;

   logic          tick;
   logic          reset;
   logic [W-1:0]  a;
   wire  [W-1:0]  y_gate;
   logic [W-1:0]  y_data, y_beh, y_reg;
   logic          mismatch;
   logic [CW-1:0] vec_count, err_count;

   logic          a_sm;
   wire           y_gate_sm;
   logic          y_data_sm, y_beh_sm, y_reg_sm, mismatch_sm;
   logic [2:0]    vec_count_sm, err_count_sm;

   int errors = 0;
   int checks = 0;

   // Model state: what the registered outputs should hold
   logic [W-1:0] exp_yreg;
   logic         exp_yreg_sm;
   longint       exp_vec, exp_err, exp_vec_sm;
   longint       max_vec;
   longint       max_vec_sm;

   not1 #(.WIDTH(W), .CNT_W(CW)) u_dut (
      .tick(tick), .reset(reset), .a(a),
      .y_gate(y_gate), .y_data(y_data), .y_beh(y_beh), .y_reg(y_reg),
      .mismatch(mismatch), .vec_count(vec_count), .err_count(err_count)
   );

   not1 #(.WIDTH(1), .CNT_W(3)) u_sm (
      .tick(tick), .reset(reset), .a(a_sm),
      .y_gate(y_gate_sm), .y_data(y_data_sm), .y_beh(y_beh_sm), .y_reg(y_reg_sm),
      .mismatch(mismatch_sm), .vec_count(vec_count_sm), .err_count(err_count_sm)
   );

   initial begin
      tick = 1'b0;
      forever #5 tick = ~tick;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1, "watchdog expired");
   end

   // One rising edge: the model follows the rules, then we move to the falling edge
   task automatic step();
      @(posedge tick);
      exp_yreg    = ~a;
      exp_yreg_sm = ~a_sm;
      if (exp_vec < max_vec) exp_vec++;
      if (exp_vec_sm < max_vec_sm) exp_vec_sm++;
      @(negedge tick);
   endtask

   task automatic model_reset();
      exp_yreg    = '0;
      exp_yreg_sm = 1'b0;
      exp_vec     = 0;
      exp_err     = 0;
      exp_vec_sm  = 0;
   endtask

   task automatic test_reset();
      a = 8'h5A; a_sm = 1'b1;
      #2;
      model_reset();
      checks++; if (y_reg !== 8'h00) begin errors++; $display("FAIL reset_yreg: got %h required 00", y_reg); end
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b required 0", mismatch); end
      checks++; if (vec_count !== 32'd0) begin errors++; $display("FAIL reset_vec: got %0d required 0", vec_count); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL reset_err: got %0d required 0", err_count); end
      checks++; if (vec_count_sm !== 3'd0) begin errors++; $display("FAIL reset_vec_sm: got %0d required 0", vec_count_sm); end
      checks++;
      if (y_gate !== 8'hA5 || y_data !== 8'hA5 || y_beh !== 8'hA5) begin
         errors++; $display("FAIL reset_comb: got %h/%h/%h required a5", y_gate, y_data, y_beh);
      end
      @(negedge tick);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      a = 8'h00;
      #1;
      checks++;
      if (y_gate !== 8'hFF || y_data !== 8'hFF || y_beh !== 8'hFF) begin
         errors++; $display("FAIL basic_comb0: got %h/%h/%h required ff", y_gate, y_data, y_beh);
      end
      step();
      checks++; if (y_reg !== exp_yreg) begin errors++; $display("FAIL basic_yreg0: got %h required %h", y_reg, exp_yreg); end
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL basic_mismatch: got %b required 0", mismatch); end
      a = 8'hFF;
      #1;
      checks++;
      if (y_gate !== 8'h00 || y_data !== 8'h00 || y_beh !== 8'h00) begin
         errors++; $display("FAIL basic_comb1: got %h/%h/%h required 00", y_gate, y_data, y_beh);
      end
      step();
      checks++; if (y_reg !== 8'h00) begin errors++; $display("FAIL basic_yreg1: got %h required 00", y_reg); end
      step();
      step();
      checks++; if (vec_count !== 32'd4) begin errors++; $display("FAIL basic_vec4: got %0d required 4", vec_count); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL basic_err0: got %0d required 0", err_count); end
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 4; i++) begin
         a = (i % 2 == 1) ? 8'hFF : 8'h00;
         step();
         checks++;
         if (y_reg !== exp_yreg) begin errors++; $display("FAIL alt_yreg[%0d]: got %h required %h", i, y_reg, exp_yreg); end
         checks++;
         if (err_count !== exp_err[CW-1:0]) begin errors++; $display("FAIL alt_err[%0d]: got %0d required %0d", i, err_count, exp_err); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         a    = W'($urandom);
         a_sm = 1'($urandom);
         #1;
         checks++;
         if (y_gate !== ~a || y_data !== ~a || y_beh !== ~a) begin
            errors++; $display("FAIL rand_comb[%0d]: got %h/%h/%h required %h", i, y_gate, y_data, y_beh, ~a);
         end
         checks++;
         if (y_gate_sm !== ~a_sm || y_data_sm !== ~a_sm || y_beh_sm !== ~a_sm) begin
            errors++; $display("FAIL rand_comb_sm[%0d]: got %b/%b/%b required %b", i, y_gate_sm, y_data_sm, y_beh_sm, ~a_sm);
         end
         step();
         checks++;
         if (y_reg !== exp_yreg || y_reg_sm !== exp_yreg_sm) begin
            errors++; $display("FAIL rand_yreg[%0d]: got %h/%b required %h/%b", i, y_reg, y_reg_sm, exp_yreg, exp_yreg_sm);
         end
         checks++;
         if (vec_count !== exp_vec[CW-1:0] || vec_count_sm !== exp_vec_sm[2:0]) begin
            errors++; $display("FAIL rand_vec[%0d]: got %0d/%0d required %0d/%0d", i, vec_count, vec_count_sm, exp_vec, exp_vec_sm);
         end
         checks++;
         if (mismatch !== 1'b0 || err_count !== exp_err[CW-1:0]) begin
            errors++; $display("FAIL rand_err[%0d]: got %b/%0d required 0/%0d", i, mismatch, err_count, exp_err);
         end
      end
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom); a_sm = 1'($urandom);
         step();
      end
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (y_reg !== 8'h00 || mismatch !== 1'b0 || vec_count !== 32'd0 || err_count !== 32'd0) begin
         errors++; $display("FAIL midreset_regs: got %h/%b/%0d/%0d required 00/0/0/0", y_reg, mismatch, vec_count, err_count);
      end
      checks++;
      if (vec_count_sm !== 3'd0 || y_reg_sm !== 1'b0) begin
         errors++; $display("FAIL midreset_sm: got %0d/%b required 0/0", vec_count_sm, y_reg_sm);
      end
      checks++;
      if (y_gate !== ~a || y_data !== ~a || y_beh !== ~a) begin
         errors++; $display("FAIL midreset_comb: got %h/%h/%h required %h", y_gate, y_data, y_beh, ~a);
      end
      @(negedge tick);
      reset = 1'b0;
      a = W'($urandom);
      step();
      checks++; if (vec_count !== 32'd1) begin errors++; $display("FAIL first_edge_vec: got %0d required 1", vec_count); end
      checks++; if (y_reg !== exp_yreg) begin errors++; $display("FAIL first_edge_yreg: got %h required %h", y_reg, exp_yreg); end
   endtask

   task automatic test_x();
      a = 'x;
      #1;
      checks++;
      if (y_gate !== ~a || y_data !== ~a || y_beh !== ~a) begin
         errors++; $display("FAIL x_comb: got %h/%h/%h required %h", y_gate, y_data, y_beh, ~a);
      end
      step();
      checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL x_mismatch: got %b required 0", mismatch); end
      checks++; if (err_count !== exp_err[CW-1:0]) begin errors++; $display("FAIL x_err: got %0d required %0d", err_count, exp_err); end
      checks++; if (y_reg !== exp_yreg) begin errors++; $display("FAIL x_yreg: got %h required %h", y_reg, exp_yreg); end
      a = 8'h00;
   endtask

   task automatic test_saturation();
      reset = 1'b1;
      #2;
      model_reset();
      reset = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         a_sm = 1'($urandom);
         step();
         checks++;
         if (vec_count_sm !== exp_vec_sm[2:0]) begin
            errors++; $display("FAIL sat_vec[%0d]: got %0d required %0d", n, vec_count_sm, exp_vec_sm);
         end
      end
      checks++; if (vec_count_sm !== 3'd7) begin errors++; $display("FAIL sat_hold: got %0d required 7", vec_count_sm); end
      checks++; if (vec_count !== 32'd9) begin errors++; $display("FAIL sat_wide: got %0d required 9", vec_count); end
      checks++; if (err_count_sm !== 3'd0) begin errors++; $display("FAIL sat_err_sm: got %0d required 0", err_count_sm); end
   endtask

   initial begin
      reset      = 1'b1;
      a          = '0;
      a_sm       = 1'b0;
      max_vec    = (longint'(1) << CW) - 1;
      max_vec_sm = 7;
      model_reset();
      test_reset();
      test_basic();
      test_alternate();
      test_random();
      test_midreset();
      test_x();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
